// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding, byte width and index-width helper for the UART TX arbiter
package uart_tx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  // Index width that never collapses to zero bits, even for tiny requester counts.
  function automatic int IDW(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first valid index above the pointer, wrapping
module rr_pick
  import uart_tx_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = IDW(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan ptr+1, ptr+2, ... ptr+N (mod N); the first valid entry wins, so the pointer itself is last.
  always_comb begin
    logic [IW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!any_o && valid_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = j;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter driving one UART transmitter; UART_TX_ARB_LOCK_EN adds packet locking
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          req_last,
`endif
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [IDW(NUM_REQ)-1:0]     grant_id,
  output logic                        err_timeout
);

  localparam int IW = IDW(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_valid;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q, lock_d;
  // While locked only the current owner may be picked; the others are masked out entirely.
  assign pick_valid = lock_q ? (req_valid & (NUM_REQ'(1) << grant_q)) : req_valid;
`else
  assign pick_valid = req_valid;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid_i (pick_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

  // Next-state and handshake outputs: accept only in IDLE with an idle transmitter, then start, then track busy.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    grant_d   = grant_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    tx_start  = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d    = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (!tx_busy && pick_any) begin
          req_ready = pick_gnt;
          data_d    = req_data[pick_idx*BYTE_W +: BYTE_W];
          grant_d   = pick_idx;
          ptr_d     = pick_idx;
          state_d   = ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_d    = !req_last[pick_idx];
`endif
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // cnt_d is the number of WAIT_BUSY cycles including this one; busy on the last allowed cycle still wins.
        cnt_d = cnt_q + CW'(1);
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_d == CW'(BUSY_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; pointer resets to the top index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      data_q  <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a timeline model and directed scenarios
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NR-1:0]   req_last = '0;
`endif
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy = 1'b0;
  logic [1:0]      grant_id;
  logic            err_timeout;

  int vecs  = 0;
  int fails = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // requester byte queues: {last, data}
  bit [8:0] q_mem [NR][16];
  int       wr_idx [NR] = '{default: 0};
  int       rd_idx [NR] = '{default: 0};

  // transmitter model: 0 normal, 1 never acknowledges, 2 busy forced to force_busy
  int  tx_mode    = 0;
  bit  force_busy = 1'b0;
  int  busy_len   = 5;
  int  busy_cnt   = 0;
  bit  start_seen = 1'b0;

  // reference model (timeline of the in-flight byte)
  int         cyc = 0;
  int         m_ptr = NR - 1;
  int         m_grant = 0;
  bit         m_inflight = 1'b0;
  bit         m_seen = 1'b0;
  bit         m_err = 1'b0;
  bit         m_lock = 1'b0;
  logic [7:0] m_data = '0;
  int         m_acc_cyc = 0;
  bit         err_prev = 1'b0;

  int         acc_id [$];
  int         acc_cyc [$];
  int         st_cyc [$];
  logic [7:0] st_data [$];
  int         err_cyc [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // stimulus drive: transmitter busy and requester heads, just after each rising edge
  always @(posedge clk) begin
    #1;
    if (start_seen) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = (tx_mode == 2) ? force_busy : (tx_mode == 1) ? 1'b0 : (busy_cnt > 0);
    for (int i = 0; i < NR; i++) begin
      req_valid[i]       = rd_idx[i] < wr_idx[i];
      req_data[i*8 +: 8] = q_mem[i][rd_idx[i] % 16][7:0];
`ifdef UART_TX_ARB_LOCK_EN
      req_last[i]        = q_mem[i][rd_idx[i] % 16][8];
`endif
    end
  end

  // compare process and model update on the falling edge
  always @(negedge clk) begin
    logic [NR-1:0] exp_ready;
    int  win;
    bit  found;
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_err", err_timeout, 0);
      m_ptr = NR - 1; m_grant = 0; m_inflight = 0; m_seen = 0;
      m_err = 0; m_lock = 0; m_data = '0;
      start_seen = 0;
      err_prev = 0;
    end else begin
      exp_ready = '0; win = 0; found = 0;
      if (!m_inflight && !tx_busy) begin
        for (int k = 1; k <= NR; k++) begin
          int j;
          j = (m_ptr + k) % NR;
          if (m_lock) j = m_grant;
          if (!found && req_valid[j]) begin
            found = 1;
            win = j;
          end
        end
        if (found) exp_ready[win] = 1'b1;
      end
      chk("req_ready", req_ready, exp_ready);
      chk("tx_start", tx_start, (m_inflight && cyc == m_acc_cyc + 1) ? 1 : 0);
      chk("tx_data", tx_data, m_data);
      chk("grant_id", grant_id, m_grant);
      chk("err_timeout", err_timeout, m_err);

      start_seen = (tx_start === 1'b1);
      if (tx_start === 1'b1) begin
        st_cyc.push_back(cyc);
        st_data.push_back(tx_data);
      end
      if (err_timeout === 1'b1 && !err_prev) err_cyc.push_back(cyc);
      err_prev = (err_timeout === 1'b1);

      if (found) begin
        m_inflight = 1; m_seen = 0; m_acc_cyc = cyc;
        m_data = req_data[win*8 +: 8];
        m_grant = win; m_ptr = win;
`ifdef UART_TX_ARB_LOCK_EN
        m_lock = !req_last[win];
`endif
        rd_idx[win]++;
        acc_id.push_back(win);
        acc_cyc.push_back(cyc);
      end else if (m_inflight && cyc > m_acc_cyc + 1) begin
        if (m_seen) begin
          if (!tx_busy) m_inflight = 0;
        end else if (tx_busy) begin
          m_seen = 1;
        end else if (cyc - (m_acc_cyc + 1) == TO) begin
          m_err = 1;
          m_inflight = 0;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    q_mem[r][wr_idx[r] % 16] = {last, d};
    wr_idx[r]++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NR; i++) wr_idx[i] = rd_idx[i];
    cycles(3);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_cnt(input string nm, input int which, input int n, input int budget);
    int cnt;
    bit ok;
    ok = 0;
    for (int b = 0; b < budget && !ok; b++) begin
      @(negedge clk);
      #1;
      cnt = (which == 0) ? acc_id.size() : (which == 1) ? st_cyc.size() : err_cyc.size();
      if (cnt >= n) ok = 1;
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    int ba, bs, be;
    logic [7:0] exp_f [5];
    int exp_l [5];
    exp_f = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

    // single request, long busy
    tx_mode = 0; busy_len = 87;
    do_reset();
    ba = acc_id.size(); bs = st_cyc.size();
    push(0, 8'h55, 1'b1);
    wait_cnt("single_accept_wait", 0, ba + 1, 20);
    push(0, 8'h56, 1'b1);
    chk("single_grant", acc_id[ba], 0);
    wait_cnt("single_start_wait", 1, bs + 1, 20);
    chk("single_start_latency", st_cyc[bs] - acc_cyc[ba], 1);
    chk("single_data", st_data[bs], 8'h55);
    chk("single_grant_id", grant_id, 0);
    wait_cnt("single_next_wait", 0, ba + 2, 150);
    chk("single_gap", acc_cyc[ba + 1] - st_cyc[bs], 89);
    cycles(100);

    // fairness, all four continuously valid
    busy_len = 5;
    do_reset();
    ba = acc_id.size(); bs = st_cyc.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    wait_cnt("fair_wait", 1, bs + 5, 100);
    for (int k = 0; k < 5; k++) begin
      chk("fair_data", st_data[bs + k], exp_f[k]);
      chk("fair_grant", acc_id[ba + k], k % NR);
    end
    cycles(60);

    // transmitter busy while idle
    tx_mode = 2; force_busy = 1'b1;
    do_reset();
    ba = acc_id.size();
    for (int i = 0; i < NR; i++) push(i, 8'hB0 + 8'(i), 1'b1);
    cycles(20);
    chk("busy_no_accept", acc_id.size() - ba, 0);
    tx_mode = 0; force_busy = 1'b0;
    wait_cnt("busy_release_wait", 0, ba + 1, 10);
    chk("busy_release_grant", acc_id[ba], 0);
    cycles(60);

    // no acknowledge from transmitter
    tx_mode = 1;
    do_reset();
    bs = st_cyc.size(); be = err_cyc.size();
    push(3, 8'h31, 1'b1);
    push(3, 8'h32, 1'b1);
    wait_cnt("to_start_wait", 1, bs + 1, 20);
    wait_cnt("to_err_wait", 2, be + 1, 40);
    chk("to_err_delay", err_cyc[be] - st_cyc[bs], 17);
    wait_cnt("to_next_wait", 1, bs + 2, 40);
    chk("to_next_data", st_data[bs + 1], 8'h32);
    chk("to_err_sticky", err_timeout, 1);
    cycles(30);
    chk("to_err_still", err_timeout, 1);
    chk("to_err_single_rise", err_cyc.size() - be, 1);
    tx_mode = 0;
    do_reset();
    @(negedge clk);
    chk("to_err_cleared", err_timeout, 0);

    // reset in the middle of a transmission
    busy_len = 40;
    do_reset();
    bs = st_cyc.size();
    push(2, 8'hC3, 1'b1);
    wait_cnt("mid_start_wait", 1, bs + 1, 20);
    cycles(10);
    push(0, 8'h11, 1'b1);
    push(1, 8'h22, 1'b1);
    @(posedge clk);
    #2;
    chk("mid_pre_data", tx_data, 8'hC3);
    chk("mid_pre_grant", grant_id, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_async_data", tx_data, 0);
    chk("mid_async_grant", grant_id, 0);
    chk("mid_async_ready", req_ready, 0);
    chk("mid_async_start", tx_start, 0);
    cycles(2);
    #2 rst_n = 1'b1;
    ba = acc_id.size();
    wait_cnt("mid_after_wait", 0, ba + 1, 60);
    chk("mid_after_grant", acc_id[ba], 0);
    cycles(100);

    // packet lock (or plain round robin when the lock feature is absent)
    busy_len = 3;
    do_reset();
    ba = acc_id.size();
    push(1, 8'h10, 1'b1);
    wait_cnt("lock_pre_wait", 0, ba + 1, 20);
    push(2, 8'h20, 1'b0);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b1);
    push(0, 8'h01, 1'b1);
`ifdef UART_TX_ARB_LOCK_EN
    exp_l = '{1, 2, 2, 2, 0};
`else
    exp_l = '{1, 2, 0, 2, 2};
`endif
    wait_cnt("lock_wait", 0, ba + 5, 80);
    for (int k = 0; k < 5; k++) chk("lock_grant", acc_id[ba + k], exp_l[k]);
    cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
